// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline stage: default widths,
// ALU control codes, the buffered entry layout and the skid buffer state.
package ex_mem_pkg;

   localparam int DEF_N     = 32;
   localparam int DEF_CTR_W = 4;
   localparam int DEF_RA_W  = 5;

   localparam logic [DEF_CTR_W-1:0] ALU_ADD  = 4'h0;
   localparam logic [DEF_CTR_W-1:0] ALU_ADDU = 4'h1;
   localparam logic [DEF_CTR_W-1:0] ALU_SUB  = 4'h2;
   localparam logic [DEF_CTR_W-1:0] ALU_SUBU = 4'h3;
   localparam logic [DEF_CTR_W-1:0] ALU_SLT  = 4'h4;
   localparam logic [DEF_CTR_W-1:0] ALU_SLTU = 4'h5;
   localparam logic [DEF_CTR_W-1:0] ALU_SLL  = 4'h6;
   localparam logic [DEF_CTR_W-1:0] ALU_SRA  = 4'h7;
   localparam logic [DEF_CTR_W-1:0] ALU_SRL  = 4'h8;
   localparam logic [DEF_CTR_W-1:0] ALU_OR   = 4'h9;
   localparam logic [DEF_CTR_W-1:0] ALU_AND  = 4'hA;
   localparam logic [DEF_CTR_W-1:0] ALU_XOR  = 4'hB;
   localparam logic [DEF_CTR_W-1:0] ALU_NOP  = 4'hF;

   typedef struct packed {
      logic [DEF_N-1:0]    result;
      logic                zero;
      logic [DEF_RA_W-1:0] rd;
      logic                regwrite;
      logic                memread;
      logic                memwrite;
      logic [DEF_N-1:0]    store_data;
      logic [DEF_N-1:0]    pc;
   } ex_mem_entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

   // Only signed ADD/SUB trap; ADDU/SUBU overflow is architecturally silent.
   function automatic logic traps(input logic trap_ovf, input logic overflow);
      return trap_ovf & overflow;
   endfunction

endpackage

// File: rtl/ex_mem_skid.sv
// Purpose: 2-entry valid/ready skid buffer over ex_mem_entry_t with flush.
// Latency: 1 cycle from accepted push to head visible on out_dat.
// Backpressure: in_rdy is registered (no out_rdy->in_rdy path); drops when full or hold_nxt.
module ex_mem_skid
   import ex_mem_pkg::*;
#(
   parameter bit TAIL_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          hold_nxt,
   input  logic          in_vld,
   input  ex_mem_entry_t in_dat,
   output logic          in_rdy,
   output logic          out_vld,
   input  logic          out_rdy,
   output ex_mem_entry_t out_dat,
   output ex_mem_entry_t tail_dat
);

   skid_state_t   state, state_nxt;
   ex_mem_entry_t head, second;
   logic          push, pop;

   assign push    = in_vld & in_rdy & ~flush;
   assign pop     = out_vld & out_rdy;
   assign out_vld = (state != EMPTY);
   assign out_dat = head;

   always_comb begin
      state_nxt = state;
      unique case (state)
         EMPTY: if (push) state_nxt = ONE;
         ONE: begin
            if (push && !pop)      state_nxt = TWO;
            else if (pop && !push) state_nxt = EMPTY;
         end
         TWO:     if (pop) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
      if (flush) state_nxt = EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         in_rdy <= 1'b1;
      end else begin
         state  <= state_nxt;
         in_rdy <= (state_nxt != TWO) && !hold_nxt;
      end
   end

   // A push while full cannot occur: in_rdy is low in TWO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head   <= '0;
         second <= '0;
      end else begin
         if (push && (state == EMPTY || (state == ONE && pop)))
            head <= in_dat;
         else if (state == TWO && pop)
            head <= second;
         if (push && state == ONE && !pop)
            second <= in_dat;
      end
   end

   generate
      if (TAIL_EN) begin : g_tail
         assign tail_dat = (state == TWO) ? second : head;
      end else begin : g_no_tail
         assign tail_dat = '0;
      end
   endgenerate

endmodule

// File: rtl/ex_mem_stage.sv
// Purpose: EX/MEM stage: skid-buffered ALU results, precise overflow trap, forwarding (EX_MEM_FWD_EN).
// Latency: 1 cycle in->out; exc_valid pulses the cycle after a trapping push.
// Backpressure: registered in_ready; held low when full or while an exception awaits flush.
module ex_mem_stage
   import ex_mem_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int CTR_W = DEF_CTR_W,
   parameter int RA_W  = DEF_RA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_result,
   input  logic             in_zero,
   input  logic             in_overflow,
   input  logic [CTR_W-1:0] in_alu_ctr,
   input  logic             in_trap_ovf,
   input  logic [RA_W-1:0]  in_rd,
   input  logic             in_regwrite,
   input  logic             in_memread,
   input  logic             in_memwrite,
   input  logic [N-1:0]     in_store_data,
   input  logic [N-1:0]     in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_result,
   output logic [N-1:0]     out_store_data,
   output logic [N-1:0]     out_pc,
   output logic             out_zero,
   output logic             out_regwrite,
   output logic             out_memread,
   output logic             out_memwrite,
   output logic [RA_W-1:0]  out_rd,
   output logic             exc_valid,
   output logic [N-1:0]     exc_epc,
   output logic             fwd_valid,
   output logic [RA_W-1:0]  fwd_rd,
   output logic [N-1:0]     fwd_result
);

`ifdef EX_MEM_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   ex_mem_entry_t in_dat, head_dat, tail_dat;
   logic          trap, push_ok, exc_pending, exc_pending_nxt;
   logic          unused_ok;

   assign trap    = traps(in_trap_ovf, in_overflow);
   assign push_ok = in_valid & in_ready & ~flush;

   // A trapping instruction must not commit any architectural side effect.
   assign in_dat = '{result:     in_result,
                     zero:       in_zero,
                     rd:         in_rd,
                     regwrite:   in_regwrite & ~trap,
                     memread:    in_memread & ~trap,
                     memwrite:   in_memwrite & ~trap,
                     store_data: in_store_data,
                     pc:         in_pc};

   assign exc_pending_nxt = ~flush & (exc_pending | (push_ok & trap));

   ex_mem_skid #(.TAIL_EN(FWD_EN)) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .hold_nxt (exc_pending_nxt),
      .in_vld   (in_valid),
      .in_dat   (in_dat),
      .in_rdy   (in_ready),
      .out_vld  (out_valid),
      .out_rdy  (out_ready),
      .out_dat  (head_dat),
      .tail_dat (tail_dat)
   );

   assign out_result     = head_dat.result;
   assign out_store_data = head_dat.store_data;
   assign out_pc         = head_dat.pc;
   assign out_zero       = head_dat.zero;
   assign out_regwrite   = head_dat.regwrite;
   assign out_memread    = head_dat.memread;
   assign out_memwrite   = head_dat.memwrite;
   assign out_rd         = head_dat.rd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_valid   <= 1'b0;
         exc_epc     <= '0;
         exc_pending <= 1'b0;
      end else begin
         exc_valid   <= push_ok & trap;
         exc_pending <= exc_pending_nxt;
         if (push_ok && trap) exc_epc <= in_pc;
      end
   end

`ifdef EX_MEM_FWD_EN
   assign fwd_valid  = out_valid & tail_dat.regwrite & (tail_dat.rd != '0);
   assign fwd_rd     = tail_dat.rd;
   assign fwd_result = tail_dat.result;
   assign unused_ok  = ^{in_alu_ctr, tail_dat.zero, tail_dat.memread, tail_dat.memwrite,
                         tail_dat.store_data, tail_dat.pc};
`else
   assign fwd_valid  = 1'b0;
   assign fwd_rd     = '0;
   assign fwd_result = '0;
   assign unused_ok  = ^{in_alu_ctr, tail_dat};
`endif

endmodule
